// File: rtl/cache_bridge_pkg.sv
// cache_bridge_pkg: shared opcode/state encodings and sizing helpers for cache_mem_bridge.
package cache_bridge_pkg;
    typedef enum logic [1:0] {
        OP_IDLE  = 2'b00,
        OP_READ  = 2'b01,
        OP_WRITE = 2'b11
    } opcode_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WB_REQ,
        S_WB_WAIT,
        S_RD_REQ,
        S_RD_WAIT,
        S_FILL
    } bridge_state_t;

    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Byte-offset bits within a cache line; forced to zero on every memory address.
    function automatic int line_off_w(input int cl_bits);
        return $clog2(cl_bits / 8);
    endfunction
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: round-robin pick among NUM_CH requests, searching upward from the slot after i_ptr.
module rr_arbiter
    import cache_bridge_pkg::*;
#(
    parameter int NUM_CH = 2,
    parameter int PW     = idx_w(NUM_CH)
) (
    input  logic [NUM_CH-1:0] i_req,
    input  logic [PW-1:0]     i_ptr,
    output logic [NUM_CH-1:0] o_grant,
    output logic [PW-1:0]     o_idx,
    output logic              o_valid
);
    always_comb begin
        o_grant = '0;
        o_idx   = '0;
        o_valid = 1'b0;
        for (int i = 1; i <= NUM_CH; i++) begin
            if (!o_valid && i_req[(int'(i_ptr) + i) % NUM_CH]) begin
                o_grant[(int'(i_ptr) + i) % NUM_CH] = 1'b1;
                o_idx   = PW'((int'(i_ptr) + i) % NUM_CH);
                o_valid = 1'b1;
            end
        end
    end
endmodule

// File: rtl/cache_mem_bridge.sv
// cache_mem_bridge: arbitrates L1 line misses onto one memory port, with optional victim writeback.
// Define MEM_TIMEOUT_EN to add a watchdog that aborts a stalled memory wait and returns an error fill.
module cache_mem_bridge
    import cache_bridge_pkg::*;
#(
    parameter int NUM_CH         = 2,
    parameter int WORD_SIZE      = 32,
    parameter int CL_SIZE_WIDTH  = 512,
    parameter int ADDR_BITCOUNT  = 32,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [NUM_CH-1:0]                 ch_miss,
    input  logic [NUM_CH*ADDR_BITCOUNT-1:0]   ch_addr,
    input  logic [NUM_CH-1:0]                 ch_wb,
    input  logic [NUM_CH*ADDR_BITCOUNT-1:0]   ch_wb_addr,
    input  logic [NUM_CH*CL_SIZE_WIDTH-1:0]   ch_wb_data,
    output logic [NUM_CH-1:0]                 fill_valid,
    output logic [NUM_CH-1:0]                 fill_err,
    output logic [CL_SIZE_WIDTH-1:0]          fill_data,
    output logic [NUM_CH-1:0]                 ch_busy,
    output logic                              mem_req_valid,
    output logic [1:0]                        mem_op,
    output logic [ADDR_BITCOUNT-1:0]          mem_addr,
    output logic [CL_SIZE_WIDTH-1:0]          mem_wdata,
    input  logic                              mem_ready,
    input  logic                              mem_rd_valid,
    input  logic [CL_SIZE_WIDTH-1:0]          mem_rdata,
    input  logic                              mem_tx_done,
    output logic                              mem_abort
);
    localparam int PW = idx_w(NUM_CH);
    localparam int OW = line_off_w(CL_SIZE_WIDTH);
    localparam logic [ADDR_BITCOUNT-1:0] LINE_MASK = {ADDR_BITCOUNT{1'b1}} << OW;

    bridge_state_t              r_state, w_nxt;
    logic [PW-1:0]              r_ptr, r_idx, w_arb_idx;
    logic [NUM_CH-1:0]          r_grant, w_arb_grant, w_grant;
    logic                       w_arb_valid, w_in_idle, w_timeout, w_abort;
    logic [ADDR_BITCOUNT-1:0]   r_addr, r_wb_addr, w_addr_sel, w_wb_addr_sel, w_mem_addr;
    logic [CL_SIZE_WIDTH-1:0]   r_wb_data, w_wb_data_sel, w_wdata;
    logic                       w_req;
    opcode_t                    w_op;
    logic [NUM_CH-1:0]          w_busy, w_fill, w_err;

    rr_arbiter #(.NUM_CH(NUM_CH), .PW(PW)) u_arb (
        .i_req  (ch_miss),
        .i_ptr  (r_ptr),
        .o_grant(w_arb_grant),
        .o_idx  (w_arb_idx),
        .o_valid(w_arb_valid)
    );

    // In IDLE the request fields come straight from the winning channel so the first request cycle is not delayed.
    assign w_in_idle     = r_state == S_IDLE;
    assign w_grant       = w_in_idle ? w_arb_grant : r_grant;
    assign w_addr_sel    = w_in_idle ? ch_addr[w_arb_idx*ADDR_BITCOUNT +: ADDR_BITCOUNT] : r_addr;
    assign w_wb_addr_sel = w_in_idle ? ch_wb_addr[w_arb_idx*ADDR_BITCOUNT +: ADDR_BITCOUNT] : r_wb_addr;
    assign w_wb_data_sel = w_in_idle ? ch_wb_data[w_arb_idx*CL_SIZE_WIDTH +: CL_SIZE_WIDTH] : r_wb_data;

`ifdef MEM_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    logic [CW-1:0] r_cnt;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_cnt <= '0;
        else     r_cnt <= (w_nxt != r_state) ? '0 : r_cnt + 1'b1;
    end
    assign w_timeout = (r_state == S_WB_WAIT || r_state == S_RD_WAIT) && r_cnt == CW'(TIMEOUT_CYCLES - 1);
`else
    // Watchdog compiled out: wait states never expire.
    assign w_timeout = TIMEOUT_CYCLES < 0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= S_IDLE;
            r_ptr         <= PW'(NUM_CH - 1);
            r_idx         <= '0;
            r_grant       <= '0;
            r_addr        <= '0;
            r_wb_addr     <= '0;
            r_wb_data     <= '0;
            mem_req_valid <= 1'b0;
            mem_op        <= OP_IDLE;
            mem_addr      <= '0;
            mem_wdata     <= '0;
            ch_busy       <= '0;
            fill_valid    <= '0;
            fill_err      <= '0;
            fill_data     <= '0;
            mem_abort     <= 1'b0;
        end else begin
            r_state <= w_nxt;
            if (w_in_idle) begin
                r_idx     <= w_arb_idx;
                r_grant   <= w_arb_grant;
                r_addr    <= w_addr_sel;
                r_wb_addr <= w_wb_addr_sel;
                r_wb_data <= w_wb_data_sel;
            end
            if (r_state == S_FILL) r_ptr <= r_idx;
            if (w_nxt == S_FILL) fill_data <= w_abort ? '0 : mem_rdata;
            mem_req_valid <= w_req;
            mem_op        <= w_op;
            mem_addr      <= w_mem_addr;
            mem_wdata     <= w_wdata;
            ch_busy       <= w_busy;
            fill_valid    <= w_fill;
            fill_err      <= w_err;
            mem_abort     <= w_abort;
        end
    end

    always_comb begin
        w_nxt = r_state;
        case (r_state)
            S_IDLE:    if (w_arb_valid) w_nxt = ch_wb[w_arb_idx] ? S_WB_REQ : S_RD_REQ;
            S_WB_REQ:  if (mem_ready) w_nxt = S_WB_WAIT;
            S_WB_WAIT: w_nxt = mem_tx_done ? S_RD_REQ : w_timeout ? S_FILL : S_WB_WAIT;
            S_RD_REQ:  if (mem_ready) w_nxt = S_RD_WAIT;
            S_RD_WAIT: if (mem_rd_valid || w_timeout) w_nxt = S_FILL;
            default:   w_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        w_abort    = w_timeout && ((r_state == S_WB_WAIT && !mem_tx_done) || (r_state == S_RD_WAIT && !mem_rd_valid));
        w_req      = w_nxt == S_WB_REQ || w_nxt == S_RD_REQ;
        w_op       = w_nxt == S_WB_REQ ? OP_WRITE : w_nxt == S_RD_REQ ? OP_READ : OP_IDLE;
        w_mem_addr = (w_nxt == S_WB_REQ ? w_wb_addr_sel : w_nxt == S_RD_REQ ? w_addr_sel : '0) & LINE_MASK;
        w_wdata    = w_nxt == S_WB_REQ ? w_wb_data_sel : '0;
        w_busy     = w_nxt != S_IDLE ? w_grant : '0;
        w_fill     = w_nxt == S_FILL ? w_grant : '0;
        w_err      = w_abort ? w_grant : '0;
    end
endmodule

// File: tb/tb_cache_mem_bridge.sv
// tb_cache_mem_bridge: directed vector table plus hand-written multi-cycle sequences for cache_mem_bridge.
module tb_cache_mem_bridge;
    localparam int N  = 2;
    localparam int A  = 32;
    localparam int CL = 512;
`ifdef MEM_TIMEOUT_EN
    localparam int TMO = 16;
`else
    localparam int TMO = 1024;
`endif

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [N-1:0]    ch_miss = '0;
    logic [N*A-1:0]  ch_addr = '0;
    logic [N-1:0]    ch_wb = '0;
    logic [N*A-1:0]  ch_wb_addr = '0;
    logic [N*CL-1:0] ch_wb_data = '0;
    logic [N-1:0]    fill_valid, fill_err, ch_busy;
    logic [CL-1:0]   fill_data, mem_wdata;
    logic            mem_req_valid, mem_abort;
    logic [1:0]      mem_op;
    logic [A-1:0]    mem_addr;
    logic            mem_ready = 1'b0;
    logic            mem_rd_valid = 1'b0;
    logic [CL-1:0]   mem_rdata = '0;
    logic            mem_tx_done = 1'b0;

    int checks = 0;
    int failures = 0;
    int hs_cnt = 0;

    cache_mem_bridge #(
        .NUM_CH(N), .WORD_SIZE(32), .CL_SIZE_WIDTH(CL), .ADDR_BITCOUNT(A), .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk(clk), .rst(rst), .ch_miss(ch_miss), .ch_addr(ch_addr), .ch_wb(ch_wb),
        .ch_wb_addr(ch_wb_addr), .ch_wb_data(ch_wb_data), .fill_valid(fill_valid),
        .fill_err(fill_err), .fill_data(fill_data), .ch_busy(ch_busy),
        .mem_req_valid(mem_req_valid), .mem_op(mem_op), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_ready(mem_ready), .mem_rd_valid(mem_rd_valid),
        .mem_rdata(mem_rdata), .mem_tx_done(mem_tx_done), .mem_abort(mem_abort)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (mem_req_valid && mem_ready) hs_cnt <= hs_cnt + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not reach its summary");
        $fatal(1);
    end

    typedef struct {
        logic [1:0]  miss;
        logic [1:0]  wb;
        logic [31:0] a0;
        logic [31:0] a1;
        logic [31:0] wa;
        logic [1:0]  grant;
        logic [31:0] rd_addr;
        logic [31:0] wb_addr;
    } vec_t;

    vec_t vecs[6];

    function automatic logic [CL-1:0] pat(input logic [31:0] s);
        logic [CL-1:0] r;
        for (int i = 0; i < CL / 32; i++) r[i*32 +: 32] = s + 32'(i) * 32'h0101_0101;
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_line(input string name, input logic [CL-1:0] act, input logic [CL-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_all_zero(input string name);
        chk({name, "_ctl"}, 32'({mem_req_valid, mem_op, fill_valid, fill_err, ch_busy, mem_abort}), 32'h0);
        chk({name, "_addr"}, mem_addr, 32'h0);
        chk_line({name, "_wdata"}, mem_wdata, '0);
        chk_line({name, "_fdata"}, fill_data, '0);
    endtask

    // Called at a negedge with the bridge in IDLE; returns at a negedge with the bridge back in IDLE.
    task automatic run_vec(input int id, input vec_t v);
        logic [CL-1:0] wd;
        wd = v.grant[1] ? pat(v.wa ^ 32'h1111_1111) : pat(v.wa);
        ch_miss    = v.miss;
        ch_wb      = v.wb;
        ch_addr    = {v.a1, v.a0};
        ch_wb_addr = {v.wa, v.wa};
        ch_wb_data = {pat(v.wa ^ 32'h1111_1111), pat(v.wa)};
        mem_ready  = 1'b1;
        @(negedge clk);
        chk($sformatf("v%0d_busy", id), 32'(ch_busy), 32'(v.grant));
        if (|(v.wb & v.grant)) begin
            chk($sformatf("v%0d_wb_req", id), 32'({mem_req_valid, mem_op}), 32'h7);
            chk($sformatf("v%0d_wb_addr", id), mem_addr, v.wb_addr);
            chk_line($sformatf("v%0d_wb_data", id), mem_wdata, wd);
            @(negedge clk);
            chk($sformatf("v%0d_wb_wait", id), 32'({mem_req_valid, mem_op}), 32'h0);
            mem_tx_done = 1'b1;
            @(negedge clk);
            mem_tx_done = 1'b0;
        end
        chk($sformatf("v%0d_rd_req", id), 32'({mem_req_valid, mem_op}), 32'h5);
        chk($sformatf("v%0d_rd_addr", id), mem_addr, v.rd_addr);
        @(negedge clk);
        chk($sformatf("v%0d_rd_wait", id), 32'(mem_req_valid), 32'h0);
        mem_rd_valid = 1'b1;
        mem_rdata    = pat(v.rd_addr);
        @(negedge clk);
        mem_rd_valid = 1'b0;
        chk($sformatf("v%0d_fill", id), 32'({fill_valid, fill_err}), 32'({v.grant, 2'b00}));
        chk_line($sformatf("v%0d_fdata", id), fill_data, pat(v.rd_addr));
        ch_miss = '0;
        @(negedge clk);
        chk($sformatf("v%0d_after", id), 32'({fill_valid, ch_busy}), 32'h0);
    endtask

    task automatic wait_req(input string name);
        int n;
        n = 0;
        while (!mem_req_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk(name, 32'(mem_req_valid), 32'h1);
    endtask

    initial begin
        logic [1:0] exp_g;
        int hs0;
        //           miss   wb     a0            a1            wa            grant  rd_addr       wb_addr
        vecs[0] = '{2'b01, 2'b00, 32'h0000_1234, 32'h0,        32'h0,        2'b01, 32'h0000_1200, 32'h0};
        vecs[1] = '{2'b10, 2'b10, 32'h0,        32'h1234_5678, 32'h8000_0040, 2'b10, 32'h1234_5640, 32'h8000_0040};
        vecs[2] = '{2'b01, 2'b01, 32'hFFFF_FFFF, 32'h0,        32'h0000_007F, 2'b01, 32'hFFFF_FFC0, 32'h0000_0040};
        vecs[3] = '{2'b11, 2'b00, 32'h1000_0000, 32'h2000_0080, 32'h0,        2'b10, 32'h2000_0080, 32'h0};
        vecs[4] = '{2'b11, 2'b00, 32'h3000_00C1, 32'h4000_0000, 32'h0,        2'b01, 32'h3000_00C0, 32'h0};
        vecs[5] = '{2'b10, 2'b10, 32'h0,        32'h0,        32'hFFFF_FFFF, 2'b10, 32'h0000_0000, 32'hFFFF_FFC0};

        repeat (3) @(negedge clk);
        chk_all_zero("reset");
        rst = 1'b0;

        for (int i = 0; i < 6; i++) run_vec(i, vecs[i]);

        // Both channels held: grants must alternate starting with channel 0.
        ch_miss = 2'b11;
        ch_wb   = 2'b00;
        ch_addr = {32'h0000_0100, 32'h0000_0200};
        for (int k = 0; k < 8; k++) begin
            exp_g = (k % 2 == 0) ? 2'b01 : 2'b10;
            wait_req($sformatf("rr%0d_req", k));
            chk($sformatf("rr%0d_busy", k), 32'(ch_busy), 32'(exp_g));
            @(negedge clk);
            mem_rd_valid = 1'b1;
            mem_rdata    = pat(32'(k));
            @(negedge clk);
            mem_rd_valid = 1'b0;
            chk($sformatf("rr%0d_fill", k), 32'(fill_valid), 32'(exp_g));
            chk_line($sformatf("rr%0d_fdata", k), fill_data, pat(32'(k)));
        end
        ch_miss = '0;
        @(negedge clk);

        // Controller stalls five cycles: request fields must hold, exactly one handshake.
        hs0       = hs_cnt;
        mem_ready = 1'b0;
        ch_miss   = 2'b01;
        ch_addr   = {32'h0, 32'hABCD_EF17};
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk($sformatf("stall%0d_req", i), 32'({mem_req_valid, mem_op}), 32'h5);
            chk($sformatf("stall%0d_addr", i), mem_addr, 32'hABCD_EF00);
        end
        mem_ready = 1'b1;
        @(negedge clk);
        chk("stall_released", 32'(mem_req_valid), 32'h0);
        chk("stall_handshakes", 32'(hs_cnt - hs0), 32'h1);
        mem_rd_valid = 1'b1;
        mem_rdata    = pat(32'hABCD_EF00);
        @(negedge clk);
        mem_rd_valid = 1'b0;
        chk("stall_fill", 32'(fill_valid), 32'h1);
        ch_miss = '0;
        @(negedge clk);

        // Requester withdraws after the grant; the fill still completes.
        ch_miss = 2'b01;
        ch_addr = {32'h0, 32'h0000_2040};
        @(negedge clk);
        chk("drop_req", 32'(mem_req_valid), 32'h1);
        ch_miss = '0;
        @(negedge clk);
        mem_rd_valid = 1'b1;
        mem_rdata    = pat(32'h2040);
        @(negedge clk);
        mem_rd_valid = 1'b0;
        chk("drop_fill", 32'(fill_valid), 32'h1);
        chk_line("drop_fdata", fill_data, pat(32'h2040));
        @(negedge clk);

`ifdef MEM_TIMEOUT_EN
        ch_miss = 2'b01;
        ch_addr = {32'h0, 32'h0000_5000};
        @(negedge clk);
        chk("tmo_req", 32'(mem_req_valid), 32'h1);
        @(negedge clk);
        for (int j = 1; j <= 16; j++) begin
            @(negedge clk);
            if (j < 16) begin
                chk($sformatf("tmo_early%0d", j), 32'({fill_valid, mem_abort}), 32'h0);
            end else begin
                chk("tmo_fill", 32'({fill_valid, fill_err, mem_abort}), 32'b01011);
                chk_line("tmo_fdata", fill_data, '0);
            end
        end
        ch_miss = '0;
        @(negedge clk);
        chk("tmo_after", 32'({fill_err, mem_abort}), 32'h0);
`endif

        // Reset while waiting for read data: everything clears and the late data is dropped.
        ch_miss = 2'b10;
        ch_addr = {32'h0BAD_F00D, 32'h0};
        @(negedge clk);
        chk("rst_req_addr", mem_addr, 32'h0BAD_F000);
        @(negedge clk);
        chk("rst_busy", 32'(ch_busy), 32'h2);
        rst = 1'b1;
        #1;
        chk_all_zero("rst_mid");
        @(negedge clk);
        rst          = 1'b0;
        ch_miss      = '0;
        mem_rd_valid = 1'b1;
        mem_rdata    = pat(32'h0BAD_F000);
        @(negedge clk);
        mem_rd_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("rst_late%0d", i), 32'({fill_valid, mem_req_valid}), 32'h0);
            chk_line($sformatf("rst_late%0d_fdata", i), fill_data, '0);
            @(negedge clk);
        end
        ch_miss = 2'b11;
        ch_addr = {32'h0000_0040, 32'h0000_0080};
        @(negedge clk);
        chk("rst_ptr_busy", 32'(ch_busy), 32'h1);
        chk("rst_ptr_addr", mem_addr, 32'h0000_0080);
        @(negedge clk);
        mem_rd_valid = 1'b1;
        mem_rdata    = pat(32'h80);
        @(negedge clk);
        mem_rd_valid = 1'b0;
        chk("rst_ptr_fill", 32'(fill_valid), 32'h1);
        ch_miss = '0;
        @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
